// File: rtl/multicycle_main_fsm_pkg.sv
// Shared constants for the multicycle RV32I control path.
// This package holds the FSM state encodings and the RV32I major opcodes.
// It also holds the ALUOp and mux-select encodings, which the ALU decoder
// and the datapath use as well.
// ctrl_t is the Moore control word that multicycle_out_decode produces.
package multicycle_main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JALR     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_FUNCT  = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'b00,
        SRC_A_OLD_PC = 2'b01,
        SRC_A_RS1    = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2   = 2'b00,
        SRC_B_IMM   = 2'b01,
        SRC_B_FOUR  = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT = 2'b00,
        RES_DATA    = 2'b01,
        RES_ALU     = 2'b10
    } result_src_t;

    // Raw per-state requests. The FSM qualifies them: wait_ready marks the
    // states whose ir_write/pc_update/instr_done must wait for mem_ready.
    typedef struct packed {
        alu_op_t     alu_op;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        result_src_t result_src;
        logic        adr_src;
        logic        ir_write;
        logic        pc_update;
        logic        branch;
        logic        reg_write;
        logic        mem_write;
        logic        instr_done;
        logic        wait_ready;
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bus between the main FSM and the datapath/ALU decoder.
//   opcode, funct3, zero, mem_ready : datapath -> FSM
//   alu_op, alu_src_a, alu_src_b, result_src, adr_src : selects, FSM -> datapath
//   ir_write, pc_write, reg_write, mem_write : write enables, FSM -> datapath
//   instr_done, illegal : status, FSM -> datapath
// The master modport is the FSM side; the slave modport is the datapath side.
interface multicycle_main_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, instr_done, illegal
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_out_decode.sv
// Purely combinational map from the FSM state to the Moore control word.
//   state : current FSM state
//   ctrl  : selects plus the raw enable requests, before handshake gating
// Unused state encodings produce an all-zero word.
module multicycle_out_decode
    import multicycle_main_fsm_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
                ctrl.wait_ready = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRC_A_OLD_PC;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEMADR, S_JALR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.wait_ready = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                ctrl.wait_ready = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRC_A_RS1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRC_A_RS1;
                ctrl.alu_op     = ALU_OP_BRANCH;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = SRC_A_OLD_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.pc_update = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core.
//   clk : core clock, rising edge
//   rst : synchronous active-high reset
//   bus : control bus (master side). It carries opcode, funct3, zero and
//         mem_ready in, and the selects, write enables, instr_done and
//         illegal out.
// USE_MEM_READY = 0 treats mem_ready as constant 1.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_main_fsm_if.master bus
);
    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   illegal_q;
    logic   ready;
    logic   gate;
    logic   taken;
    logic   unused_funct3;

    assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_q <= illegal_q | (state_next == S_ILLEGAL);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JALR:     state_next = S_JAL;
            S_JAL:      state_next = S_ALUWB;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_FETCH;
        endcase
    end

    multicycle_out_decode u_out_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    // Only funct3[0] (bne vs beq) matters here.
    assign unused_funct3 = ^bus.funct3[2:1];
    assign taken = bus.funct3[0] ? ~bus.zero : bus.zero;
    assign gate  = ctrl.wait_ready ? ready : 1'b1;

    assign bus.alu_op     = ctrl.alu_op;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.result_src = ctrl.result_src;
    assign bus.adr_src    = ctrl.adr_src;

    // Enables and status are forced low while rst is held, so a reset
    // in mid-instruction causes no further writes.
    assign bus.ir_write   = ~rst & ctrl.ir_write & gate;
    assign bus.pc_write   = ~rst & ((ctrl.pc_update & gate) | (ctrl.branch & taken));
    assign bus.reg_write  = ~rst & ctrl.reg_write;
    assign bus.mem_write  = ~rst & ctrl.mem_write;
    assign bus.instr_done = ~rst & ctrl.instr_done & gate;
    assign bus.illegal    = ~rst & illegal_q;
endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
Main control FSM for the multicycle RV32I core. It sits directly upstream of the ALU decoder and supplies its 2-bit ALUOp. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. Memory accesses use a ready handshake so that wait states are supported.

Parameters:
USE_MEM_READY, 1, when 1 the FETCH/MEMREAD/MEMWRITE states wait for mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]; bit 0 selects bne (1) or beq (0)
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access this cycle
alu_op  out  2  to the ALU decoder: 00 add, 01 branch-subtract, 10 funct-decoded
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
result_src  out  2  00 ALUOut, 01 Data, 10 ALU result
adr_src  out  1  0 PC, 1 ALUOut
ir_write  out  1  load the instruction register
pc_write  out  1  PC load enable, equal to pc_update | (branch & taken)
reg_write  out  1  register file write
mem_write  out  1  data memory write
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  sticky flag: an unsupported opcode was decoded

Behaviour:
- State register is 4 bits. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, JAL 8, ALUWB 9, BRANCH 10, JALR 11, ILLEGAL 12. Unused encodings go to FETCH.
- Reset: state becomes FETCH. While rst=1, all enables (ir_write, pc_write, reg_write, mem_write), instr_done and illegal are 0. Reset taken mid-instruction aborts that instruction with no further writes.
- Outputs are Moore, decoded from state. The exceptions are pc_write, which uses zero and funct3, and the handshake-gated enables. Any select not listed below is 00/0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_write are asserted only when mem_ready=1, and the state moves to DECODE in that cycle. Otherwise the state holds.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other opcode -> ILLEGAL
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1 every cycle until mem_ready. On the mem_ready cycle it asserts instr_done and goes to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. taken = funct3[0] ? ~zero : zero, and pc_write=taken. Asserts instr_done, then FETCH.
- JALR: alu_src_a=10, alu_src_b=01, alu_op=00 (ALUOut <= rs1+imm), then JAL.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC <= ALUOut, ALU computes OldPC+4), then ALUWB.
- ILLEGAL: all enables 0. illegal is set and stays set. The state holds until rst.
- Latency, with zero wait states, in cycles:
  - lw 5, sw 4
  - R-type and I-type 4
  - branch 3
  - jal 4, jalr 5
- Each wait cycle with mem_ready=0 adds exactly 1 cycle.

Decomposition:
- Shared package: state encodings, opcode constants, ALUOp, alu_src_a, alu_src_b and result_src encodings. The ALU decoder and the datapath use the same constants.
- One natural sub-module, multicycle_out_decode: a purely combinational map from state to the Moore outputs. The FSM keeps next-state logic, the handshake gating, pc_write and the sticky illegal flag.

Test Plan:
- Reset: rst high for 2 cycles, then low with opcode=0110011 and mem_ready=1 -> state FETCH, all enables 0 during reset; ir_write=1 in the first cycle after reset.
- add (opcode 0110011), mem_ready=1 -> sequence FETCH, DECODE, EXECR, ALUWB; alu_op=10 in EXECR; reg_write=1 and instr_done=1 in cycle 4 only.
- lw with mem_ready low for 2 cycles in MEMREAD -> 7 cycles in total; adr_src=1 held throughout MEMREAD; reg_write pulses once, in MEMWB.
- beq/bne (opcode 1100011): funct3=000 with zero=1 -> pc_write=1 in BRANCH; funct3=001 with zero=1 -> pc_write=0; funct3=001 with zero=0 -> pc_write=1.
- jalr (opcode 1100111) -> sequence JALR, JAL, ALUWB; pc_write=1 only in JAL; total 5 cycles.
- opcode 1111111 -> ILLEGAL, illegal=1 held for 10 cycles with no enables asserted; rst clears it and the FSM returns to FETCH.
